ram_2p_hs: RTL and testbench

Parametrised two-port simulation memory for the NPC core. It replaces the combinational DPI RAM with on-chip storage and valid/ready request/response handshakes on an instruction port and a data port. Each port has its own latency. Out-of-range accesses are reported as errors. The block sits between the IFU/LSU and the memory map and lets the core be exercised against non-zero memory latency.

---
 rtl/ram_2p_hs_if.sv | 41 ++++
 rtl/ram_2p_hs.sv | 177 +++++++++++++++++
 tb/tb_ram_2p_hs.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_2p_hs_if.sv
// Valid/ready request/response bundle for the two-port RAM: an instruction
// fetch port (imem) and a load/store data port (dmem).
interface ram_2p_hs_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  imem_req_valid;
   logic                  imem_req_ready;
   logic [ADDR_W-1:0]     imem_req_addr;
   logic                  imem_resp_valid;
   logic                  imem_resp_ready;
   logic [DATA_W-1:0]     imem_resp_data;
   logic                  imem_resp_err;

   logic                  dmem_req_valid;
   logic                  dmem_req_ready;
   logic [ADDR_W-1:0]     dmem_req_addr;
   logic                  dmem_req_wen;
   logic [DATA_W-1:0]     dmem_req_wdata;
   logic [DATA_W/8-1:0]   dmem_req_wmask;
   logic                  dmem_resp_valid;
   logic                  dmem_resp_ready;
   logic [DATA_W-1:0]     dmem_resp_data;
   logic                  dmem_resp_err;

   modport master (
      output imem_req_valid, imem_req_addr, imem_resp_ready,
             dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata,
             dmem_req_wmask, dmem_resp_ready,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
             dmem_req_ready, dmem_resp_valid, dmem_resp_data, dmem_resp_err
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, imem_resp_ready,
             dmem_req_valid, dmem_req_addr, dmem_req_wen, dmem_req_wdata,
             dmem_req_wmask, dmem_resp_ready,
      output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
             dmem_req_ready, dmem_resp_valid, dmem_resp_data, dmem_resp_err
   );
endinterface

// File: rtl/ram_2p_hs.sv
// Two-port simulation RAM with per-port valid/ready handshakes and latency.
// Optional RAM_RAND_DELAY_EN: per-request latency drawn from an 8-bit LFSR per port.
//
// state  | meaning
// S_IDLE | req_ready=1, waiting for a request
// S_WAIT | latency counter running down to zero
// S_RESP | resp_valid=1, outputs held until resp_ready
module ram_2p_hs #(
   parameter int                ADDR_W  = 32,
   parameter int                DATA_W  = 32,
   parameter int                DEPTH   = 4096,
   parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(32'h8000_0000),
   parameter int                LATENCY = 1
) (
   input logic        clk,
   input logic        rst_n,
   ram_2p_hs_if.slave bus
);
   localparam int BYTES   = DATA_W / 8;
   localparam int OFF_LSB = $clog2(BYTES);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * BYTES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];

   state_t            r_i_state, r_d_state;
   logic [CNT_W-1:0]  r_i_cnt, r_d_cnt;
   logic [IDX_W-1:0]  r_i_idx, r_d_idx;
   logic              r_i_in_rng, r_d_in_rng, r_d_wen;
   logic              r_i_req_ready, r_d_req_ready;
   logic              r_i_resp_valid, r_d_resp_valid;
   logic [DATA_W-1:0] r_i_resp_data, r_d_resp_data;
   logic              r_i_resp_err, r_d_resp_err;

   logic [ADDR_W-1:0] w_i_off, w_d_off;
   logic              w_i_in_rng, w_d_in_rng;
   logic [IDX_W-1:0]  w_i_idx, w_d_idx;
   logic              w_i_acc, w_d_acc, w_d_wr;
   logic [CNT_W-1:0]  w_i_lat, w_d_lat;
   logic [DATA_W-1:0] w_i_rd;

   assign w_i_off    = bus.imem_req_addr - BASE;
   assign w_d_off    = bus.dmem_req_addr - BASE;
   assign w_i_in_rng = ({1'b0, w_i_off} < SPAN);
   assign w_d_in_rng = ({1'b0, w_d_off} < SPAN);
   assign w_i_idx    = w_i_off[OFF_LSB +: IDX_W];
   assign w_d_idx    = w_d_off[OFF_LSB +: IDX_W];
   assign w_i_acc    = (r_i_state == S_IDLE) && bus.imem_req_valid;
   assign w_d_acc    = (r_d_state == S_IDLE) && bus.dmem_req_valid;
   assign w_d_wr     = rst_n && w_d_acc && bus.dmem_req_wen && w_d_in_rng;

`ifdef RAM_RAND_DELAY_EN
   logic [7:0] r_i_lfsr, r_d_lfsr;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign w_i_lat = CNT_W'(32'(r_i_lfsr) % LATENCY);
   assign w_d_lat = CNT_W'(32'(r_d_lfsr) % LATENCY);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i_lfsr <= 8'hA5;
         r_d_lfsr <= 8'h5A;
      end else begin
         if (w_i_acc) r_i_lfsr <= lfsr_next(r_i_lfsr);
         if (w_d_acc) r_d_lfsr <= lfsr_next(r_d_lfsr);
      end
   end
`else
   assign w_i_lat = CNT_W'(LATENCY - 1);
   assign w_d_lat = CNT_W'(LATENCY - 1);
`endif

   // Stores commit at the accept edge; storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_d_wr) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.dmem_req_wmask[b]) r_mem[w_d_idx][b*8 +: 8] <= bus.dmem_req_wdata[b*8 +: 8];
         end
      end
   end

   // Fetch capture sees a store landing on the same edge (write-first).
   always_comb begin
      w_i_rd = r_mem[r_i_idx];
      if (w_d_wr && (w_d_idx == r_i_idx)) begin
         for (int b = 0; b < BYTES; b++) begin
            if (bus.dmem_req_wmask[b]) w_i_rd[b*8 +: 8] = bus.dmem_req_wdata[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_i_state      <= S_IDLE;
         r_i_cnt        <= '0;
         r_i_req_ready  <= 1'b1;
         r_i_resp_valid <= 1'b0;
         r_i_resp_data  <= '0;
         r_i_resp_err   <= 1'b0;
      end else begin
         case (r_i_state)
            S_IDLE: if (w_i_acc) begin
               r_i_idx       <= w_i_idx;
               r_i_in_rng    <= w_i_in_rng;
               r_i_cnt       <= w_i_lat;
               r_i_req_ready <= 1'b0;
               r_i_state     <= S_WAIT;
            end
            S_WAIT: if (r_i_cnt == '0) begin
               r_i_resp_data  <= r_i_in_rng ? w_i_rd : '0;
               r_i_resp_err   <= !r_i_in_rng;
               r_i_resp_valid <= 1'b1;
               r_i_state      <= S_RESP;
            end else begin
               r_i_cnt <= r_i_cnt - 1'b1;
            end
            S_RESP: if (bus.imem_resp_ready) begin
               r_i_resp_valid <= 1'b0;
               r_i_req_ready  <= 1'b1;
               r_i_state      <= S_IDLE;
            end
            default: r_i_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d_state      <= S_IDLE;
         r_d_cnt        <= '0;
         r_d_req_ready  <= 1'b1;
         r_d_resp_valid <= 1'b0;
         r_d_resp_data  <= '0;
         r_d_resp_err   <= 1'b0;
      end else begin
         case (r_d_state)
            S_IDLE: if (w_d_acc) begin
               r_d_idx       <= w_d_idx;
               r_d_in_rng    <= w_d_in_rng;
               r_d_wen       <= bus.dmem_req_wen;
               r_d_cnt       <= w_d_lat;
               r_d_req_ready <= 1'b0;
               r_d_state     <= S_WAIT;
            end
            S_WAIT: if (r_d_cnt == '0) begin
               r_d_resp_data  <= (r_d_wen || !r_d_in_rng) ? '0 : r_mem[r_d_idx];
               r_d_resp_err   <= !r_d_in_rng;
               r_d_resp_valid <= 1'b1;
               r_d_state      <= S_RESP;
            end else begin
               r_d_cnt <= r_d_cnt - 1'b1;
            end
            S_RESP: if (bus.dmem_resp_ready) begin
               r_d_resp_valid <= 1'b0;
               r_d_req_ready  <= 1'b1;
               r_d_state      <= S_IDLE;
            end
            default: r_d_state <= S_IDLE;
         endcase
      end
   end

   assign bus.imem_req_ready  = r_i_req_ready;
   assign bus.imem_resp_valid = r_i_resp_valid;
   assign bus.imem_resp_data  = r_i_resp_data;
   assign bus.imem_resp_err   = r_i_resp_err;
   assign bus.dmem_req_ready  = r_d_req_ready;
   assign bus.dmem_resp_valid = r_d_resp_valid;
   assign bus.dmem_resp_data  = r_d_resp_data;
   assign bus.dmem_resp_err   = r_d_resp_err;
endmodule

// File: tb/tb_ram_2p_hs.sv
// Directed bench for ram_2p_hs at LATENCY=3, DEPTH=4096, fixed-latency build.
module tb_ram_2p_hs;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   ram_2p_hs_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   ram_2p_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(4096),
               .BASE(32'h8000_0000), .LATENCY(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic d_xact(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [3:0] wmask, output logic [31:0] data,
                         output logic err, output int lat);
      int n = 0;
      while (!bus.dmem_req_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("d_req_ready", 64'(bus.dmem_req_ready), 64'h1);
      bus.dmem_req_addr  = addr;
      bus.dmem_req_wen   = wen;
      bus.dmem_req_wdata = wdata;
      bus.dmem_req_wmask = wmask;
      bus.dmem_req_valid = 1'b1;
      @(posedge clk); #1;
      bus.dmem_req_valid = 1'b0;
      lat = 0;
      while (!bus.dmem_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      data = bus.dmem_resp_data;
      err  = bus.dmem_resp_err;
      bus.dmem_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.dmem_resp_ready = 1'b0;
   endtask

   task automatic i_xact(input logic [31:0] addr, output logic [31:0] data,
                         output logic err, output int lat);
      int n = 0;
      while (!bus.imem_req_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("i_req_ready", 64'(bus.imem_req_ready), 64'h1);
      bus.imem_req_addr  = addr;
      bus.imem_req_valid = 1'b1;
      @(posedge clk); #1;
      bus.imem_req_valid = 1'b0;
      lat = 0;
      while (!bus.imem_resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      data = bus.imem_resp_data;
      err  = bus.imem_resp_err;
      bus.imem_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.imem_resp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] data;
      logic        err;
      int          lat;
      logic        seen;

      bus.imem_req_valid  = 1'b1;
      bus.imem_req_addr   = 32'h8000_0000;
      bus.imem_resp_ready = 1'b0;
      bus.dmem_req_valid  = 1'b1;
      bus.dmem_req_addr   = 32'h8000_0000;
      bus.dmem_req_wen    = 1'b1;
      bus.dmem_req_wdata  = 32'hFFFF_FFFF;
      bus.dmem_req_wmask  = 4'hF;
      bus.dmem_resp_ready = 1'b0;

      // reset with both ports requesting
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_ready", 64'(bus.imem_req_ready), 64'h1);
      chk("rst_i_valid", 64'(bus.imem_resp_valid), 64'h0);
      chk("rst_i_data",  64'(bus.imem_resp_data), 64'h0);
      chk("rst_i_err",   64'(bus.imem_resp_err), 64'h0);
      chk("rst_d_ready", 64'(bus.dmem_req_ready), 64'h1);
      chk("rst_d_valid", 64'(bus.dmem_resp_valid), 64'h0);
      chk("rst_d_data",  64'(bus.dmem_resp_data), 64'h0);
      chk("rst_d_err",   64'(bus.dmem_resp_err), 64'h0);
      bus.imem_req_valid = 1'b0;
      bus.dmem_req_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_i_ready", 64'(bus.imem_req_ready), 64'h1);
      chk("post_rst_d_ready", 64'(bus.dmem_req_ready), 64'h1);

      // masked stores then load
      d_xact(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'b1111, data, err, lat);
      chk("st1_lat", 64'(lat), 64'd3);
      chk("st1_data", 64'(data), 64'h0);
      chk("st1_err", 64'(err), 64'h0);
      d_xact(32'h8000_0010, 1'b1, 32'h0000_00AA, 4'b0001, data, err, lat);
      chk("st2_lat", 64'(lat), 64'd3);
      d_xact(32'h8000_0010, 1'b0, 32'h0, 4'h0, data, err, lat);
      chk("ld1_lat", 64'(lat), 64'd3);
      chk("ld1_data", 64'(data), 64'hDEAD_BEAA);
      chk("ld1_err", 64'(err), 64'h0);

      // zero mask store writes nothing but still responds
      d_xact(32'h8000_0010, 1'b1, 32'hFFFF_FFFF, 4'b0000, data, err, lat);
      chk("st0_lat", 64'(lat), 64'd3);
      chk("st0_err", 64'(err), 64'h0);
      i_xact(32'h8000_0012, data, err, lat);
      chk("fetch_lat", 64'(lat), 64'd3);
      chk("fetch_unaligned_data", 64'(data), 64'hDEAD_BEAA);

      // out of range; 0x8000_4000 aliases word 0 if the range check is missing
      d_xact(32'h8000_0000, 1'b1, 32'h0102_0304, 4'hF, data, err, lat);
      d_xact(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, data, err, lat);
      chk("oor_ld_err", 64'(err), 64'h1);
      chk("oor_ld_data", 64'(data), 64'h0);
      i_xact(32'h8000_4000, data, err, lat);
      chk("oor_if_err", 64'(err), 64'h1);
      chk("oor_if_data", 64'(data), 64'h0);
      d_xact(32'h8000_4000, 1'b1, 32'h5555_AAAA, 4'hF, data, err, lat);
      chk("oor_st_err", 64'(err), 64'h1);
      d_xact(32'h8000_0000, 1'b0, 32'h0, 4'h0, data, err, lat);
      chk("oor_st_nowrite", 64'(data), 64'h0102_0304);
      d_xact(32'h8000_3FFC, 1'b1, 32'h0BAD_F00D, 4'hF, data, err, lat);
      chk("last_st_err", 64'(err), 64'h0);
      i_xact(32'h8000_3FFC, data, err, lat);
      chk("last_if_err", 64'(err), 64'h0);
      chk("last_if_data", 64'(data), 64'h0BAD_F00D);

      // backpressure on imem while a dmem load completes
      bus.dmem_resp_ready = 1'b1;
      bus.imem_req_addr   = 32'h8000_0010;
      bus.imem_req_valid  = 1'b1;
      bus.dmem_req_addr   = 32'h8000_0000;
      bus.dmem_req_wen    = 1'b0;
      bus.dmem_req_valid  = 1'b1;
      @(posedge clk); #1;
      bus.imem_req_valid = 1'b0;
      bus.dmem_req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("bp_i_valid", 64'(bus.imem_resp_valid), 64'h1);
      chk("bp_i_data", 64'(bus.imem_resp_data), 64'hDEAD_BEAA);
      chk("bp_d_valid", 64'(bus.dmem_resp_valid), 64'h1);
      chk("bp_d_data", 64'(bus.dmem_resp_data), 64'h0102_0304);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", 64'(bus.imem_resp_valid), 64'h1);
         chk("bp_hold_data", 64'(bus.imem_resp_data), 64'hDEAD_BEAA);
         chk("bp_hold_ready", 64'(bus.imem_req_ready), 64'h0);
      end
      chk("bp_d_done_ready", 64'(bus.dmem_req_ready), 64'h1);
      chk("bp_d_done_valid", 64'(bus.dmem_resp_valid), 64'h0);
      bus.dmem_resp_ready = 1'b0;
      bus.imem_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.imem_resp_ready = 1'b0;
      chk("bp_i_release_ready", 64'(bus.imem_req_ready), 64'h1);
      chk("bp_i_release_valid", 64'(bus.imem_resp_valid), 64'h0);

      // store lands on the edge where the fetch captures the same word
      d_xact(32'h8000_0020, 1'b1, 32'h1111_1111, 4'hF, data, err, lat);
      bus.imem_req_addr  = 32'h8000_0020;
      bus.imem_req_valid = 1'b1;
      @(posedge clk); #1;
      bus.imem_req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.dmem_req_addr   = 32'h8000_0020;
      bus.dmem_req_wen    = 1'b1;
      bus.dmem_req_wdata  = 32'h1234_5678;
      bus.dmem_req_wmask  = 4'hF;
      bus.dmem_req_valid  = 1'b1;
      bus.dmem_resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.dmem_req_valid = 1'b0;
      chk("col_i_valid", 64'(bus.imem_resp_valid), 64'h1);
      chk("col_i_data", 64'(bus.imem_resp_data), 64'h1234_5678);
      bus.imem_resp_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      bus.imem_resp_ready = 1'b0;
      bus.dmem_resp_ready = 1'b0;
      d_xact(32'h8000_0020, 1'b0, 32'h0, 4'h0, data, err, lat);
      chk("col_d_data", 64'(data), 64'h1234_5678);

      // reset one cycle after a load is accepted
      d_xact(32'h8000_0030, 1'b1, 32'hCAFE_F00D, 4'hF, data, err, lat);
      bus.dmem_req_addr  = 32'h8000_0030;
      bus.dmem_req_wen   = 1'b0;
      bus.dmem_req_valid = 1'b1;
      @(posedge clk); #1;
      bus.dmem_req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.dmem_resp_valid) seen = 1'b1;
      end
      chk("rst_mid_no_valid", 64'(seen), 64'h0);
      chk("rst_mid_ready", 64'(bus.dmem_req_ready), 64'h1);
      d_xact(32'h8000_0030, 1'b0, 32'h0, 4'h0, data, err, lat);
      chk("rst_mid_data", 64'(data), 64'hCAFE_F00D);
      chk("rst_mid_lat", 64'(lat), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
